// File: rtl/abro_input_cond.sv
// abro_input_cond: input conditioning for the ABRO controller.
//
// Three raw asynchronous event lines (a_raw, b_raw, r_raw) are each
// synchronised, debounced and rising-edge detected. The result is clean
// single-cycle pulses A, B and R in the clk domain. An R event preempts
// A and B events that occur in the same cycle, and drop flags that.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   a_raw - raw A line (asynchronous, may bounce)
//   b_raw - raw B line (asynchronous, may bounce)
//   r_raw - raw R line (asynchronous, may bounce)
//   A     - one-cycle pulse per debounced rising edge of a_raw, unless preempted by R
//   B     - one-cycle pulse per debounced rising edge of b_raw, unless preempted by R
//   R     - one-cycle pulse per debounced rising edge of r_raw
//   drop  - one-cycle pulse when an A and/or B pulse was suppressed by R
module abro_input_cond #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  input  logic r_raw,
  output logic A,
  output logic B,
  output logic R,
  output logic drop
);

  localparam int unsigned CntW = $clog2(DB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  // Channel index: 0 = A, 1 = B, 2 = R.
  logic [2:0] w_raw;
  logic [2:0] w_sync;
  logic [2:0] w_lvl_d;
  logic [2:0] w_rise;

  logic [SYNC_STAGES-1:0] r_sync [3];
  logic [CntW-1:0]        r_cnt  [3];
  logic [CntW-1:0]        w_cnt_d [3];
  logic [2:0]             r_lvl;

  logic r_a_pulse;
  logic r_b_pulse;
  logic r_r_pulse;
  logic r_drop;

  assign w_raw = {r_raw, b_raw, a_raw};

  // Debounce next-state: the level only moves after DB_CYCLES consecutive
  // synchronised samples disagree with it; any agreeing sample restarts.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_sync[i]  = r_sync[i][SYNC_STAGES-1];
      w_lvl_d[i] = r_lvl[i];
      w_cnt_d[i] = '0;
      if (w_sync[i] != r_lvl[i]) begin
        if (r_cnt[i] == CntMax) begin
          w_lvl_d[i] = w_sync[i];
        end else begin
          w_cnt_d[i] = r_cnt[i] + CntW'(1);
        end
      end
    end
    w_rise = w_lvl_d & ~r_lvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_lvl     <= '0;
      r_a_pulse <= 1'b0;
      r_b_pulse <= 1'b0;
      r_r_pulse <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
        r_cnt[i]  <= w_cnt_d[i];
      end
      r_lvl <= w_lvl_d;
      // Preemption is applied before the output register so every output
      // is a flop; suppressed A/B events are lost, not deferred.
      r_r_pulse <= w_rise[2];
      r_a_pulse <= w_rise[0] & ~w_rise[2];
      r_b_pulse <= w_rise[1] & ~w_rise[2];
      r_drop    <= w_rise[2] & (w_rise[0] | w_rise[1]);
    end
  end

  assign A    = r_a_pulse;
  assign B    = r_b_pulse;
  assign R    = r_r_pulse;
  assign drop = r_drop;

endmodule
